shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Sequencing controller for the 8-bit left/right shift register used on the LED board. It generates the slow shift tick, selects the shift direction each tick, and implements four display patterns: rotate-left, rotate-right, ping-pong and fill/drain. Start/stop/pause come from debounced push-button pulses, and it drives the LED bus `Q` through an internal datapath sub-module.

## Interface
- `WIDTH`, 8: register width; must be ≥ 2.
- `DIV`, 25_000_000: clocks per shift tick; must be ≥ 2. Benches use 4.
- `SEED`, 8'b0000_0001: pattern loaded on start for modes 0–2.
- `clk` input 1: single system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high; the only reset.
- `start` input 1: one-cycle pulse. Starts from IDLE, resumes from PAUSE.
- `stop` input 1: one-cycle pulse. Pauses from RUN, returns to IDLE from PAUSE.
- `mode` input 2: pattern select, sampled only on start from IDLE.
  - 0 rotate-left (toward MSB)
  - 1 rotate-right
  - 2 ping-pong
  - 3 fill/drain
- `Q` output WIDTH: register contents (LEDs).
- `lr` output 1: current direction; 0 = left/toward MSB, 1 = right.
- `busy` output 1: high in RUN and PAUSE.
- `tick` output 1: one-cycle strobe on each cycle where a shift occurs.

## Operation
- FSM states: IDLE, RUN, PAUSE.
- Reset: state = IDLE, `Q` = 0, `lr` = 0, `busy` = 0, `tick` = 0, divider = 0, mode register = 0, fill flag = 0.
- IDLE + `start`:
  - latch `mode`; go to RUN.
  - `Q` = SEED for modes 0–2, `Q` = 0 for mode 3.
  - `lr` = 1 for mode 1, else 0; divider cleared.
- RUN: divider counts 0..DIV-1. When divider = DIV-1, divider wraps to 0, `tick` = 1 and one shift happens.
  - Mode 0: `Q` ← {Q[W-2:0], Q[W-1]}.
  - Mode 1: `Q` ← {Q[0], Q[W-1:1]}.
  - Mode 2, direction check at the tick:
    - `lr` = 0 and Q[W-1] = 1: set `lr` = 1 and shift right on the same tick, so the dot never leaves the register.
    - `lr` = 1 and Q[0] = 1: set `lr` = 0 and shift left on the same tick.
    - Otherwise shift in the current direction, zero-filled.
  - Mode 3: shift left, inserting the fill bit at Q[0]. Fill bit is 1 until `Q` is all ones, then 0 until `Q` is all zeros, then 1 again. The flag toggles on the tick that produces all-ones or all-zeros. Sequence from 0: 01, 03, …, FF, FE, FC, …, 00, 01, … (period 2·WIDTH ticks). `lr` stays 0.
- RUN + `stop`: go to PAUSE. `Q`, `lr`, divider and fill flag hold. No shift that cycle, even if the divider is at DIV-1.
- PAUSE + `start`: go to RUN; divider resumes from its held value.
- PAUSE + `stop`: go to IDLE, `Q` = 0, `lr` = 0.
- `start` and `stop` in the same cycle: `stop` wins in every state. In IDLE both are ignored.
- `start` in RUN: ignored; mode is not re-sampled. `mode` changes outside IDLE+start: ignored.
- Reset mid-operation: immediate return to reset values on that edge; no residual tick.

## Timing
- `start` sampled at edge k (IDLE): `Q` = SEED and `busy` = 1 visible after edge k.
- First shift occurs at edge k+DIV, and every DIV edges after that.
- `tick` is registered and high for exactly the cycle following the shifting edge, together with the new `Q`.
- Pause/resume preserves phase: total RUN cycles between ticks is always DIV.
- `stop` sampled at edge j: `busy` goes low after edge j+1 (PAUSE→IDLE needs a second `stop`).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `shift_seq_pkg`:
  - state enum (IDLE, RUN, PAUSE)
  - mode constants (MODE_ROTL, MODE_ROTR, MODE_PONG, MODE_FILL)
  - direction constants (DIR_LEFT = 0, DIR_RIGHT = 1)
- Sub-module `shreg_lr`: WIDTH-bit register with inputs `load`, `load_val`, `shift_en`, `lr`, `ser_in`, `rotate`, and output `Q`. The controller computes `ser_in` and `rotate` and owns the FSM, divider and fill flag.

## Test plan
All scenarios use DIV = 4, WIDTH = 8.
- Reset then start mode 0 → `Q` = 01, then 02, 04, …, 80, 01 at ticks 1–8. `tick` pulses every 4 cycles; `lr` = 0.
- Start mode 2 → 01, 02, …, 80, then 40 with `lr` = 1 on the same tick, …, 01, then 02 with `lr` = 0. `Q` is never 00.
- Start mode 3 → ticks give 01, 03, 07, …, FF, FE, FC, …, 80, 00, 01. Period is 16 ticks.
- Mode 1, stop two cycles after a tick, hold 10 cycles, start → `Q` is frozen during PAUSE. The next tick arrives 2 RUN cycles after resume; `busy` stays 1 throughout.
- `start` and `stop` together in RUN → PAUSE. A second `stop` → IDLE with `Q` = 00 and `busy` = 0. `start` while in RUN with a different `mode` → pattern unchanged.
- Reset asserted mid-RUN at divider = 3 → next cycle `Q` = 00, `tick` = 0, state IDLE. `start` after reset → first tick exactly 4 cycles later.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the LED shift-register sequencing controller.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ROTL = 2'd0;
  localparam logic [1:0] MODE_ROTR = 2'd1;
  localparam logic [1:0] MODE_PONG = 2'd2;
  localparam logic [1:0] MODE_FILL = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shreg_lr.sv
// WIDTH-bit bidirectional shift register with parallel load and rotate/serial-fill selection.
module shreg_lr
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             lr,
  input  logic             ser_in,
  input  logic             rotate,
  output logic [WIDTH-1:0] Q
);

  logic left_in;
  logic right_in;

  // Bit entering the vacated end: wrapped-around bit when rotating, else the serial input.
  always_comb begin
    left_in  = 1'b0;
    right_in = 1'b0;
    if (rotate) begin
      left_in  = Q[WIDTH-1];
      right_in = Q[0];
    end else begin
      left_in  = ser_in;
      right_in = ser_in;
    end
  end

  // Register contents; load has priority over shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q <= '0;
    end else if (load) begin
      Q <= load_val;
    end else if (shift_en) begin
      if (lr == DIR_LEFT) begin
        Q <= {Q[WIDTH-2:0], left_in};
      end else begin
        Q <= {right_in, Q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller: tick divider, start/stop/pause FSM and pattern selection driving shreg_lr.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DIV   = 25_000_000,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] Q,
  output logic             lr,
  output logic             busy,
  output logic             tick
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t           state;
  state_t           next_state;
  logic [DW-1:0]    div_cnt;
  logic [1:0]       mode_reg;
  logic             fill_flag;

  logic             start_go;
  logic             go_idle;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             count_en;
  logic             shift_en;
  logic             shift_dir;
  logic             ser_in;
  logic             rotate;
  logic             pong_dir;
  logic [WIDTH-1:0] fill_next;
  logic             fill_edge;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; stop dominates start everywhere.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && !stop) next_state = RUN;
        else                next_state = IDLE;
      end
      RUN: begin
        if (stop) next_state = PAUSE;
        else      next_state = RUN;
      end
      PAUSE: begin
        if (stop)       next_state = IDLE;
        else if (start) next_state = RUN;
        else            next_state = PAUSE;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM-decoded controls: load on start/abort, count and shift only in uninterrupted RUN.
  always_comb begin
    start_go = 1'b0;
    go_idle  = 1'b0;
    count_en = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) start_go = 1'b1;
        else                start_go = 1'b0;
      end
      RUN: begin
        if (!stop) begin
          count_en = 1'b1;
          shift_en = (div_cnt == DIV_LAST);
        end else begin
          count_en = 1'b0;
          shift_en = 1'b0;
        end
      end
      PAUSE: begin
        if (stop) go_idle = 1'b1;
        else      go_idle = 1'b0;
      end
      default: begin
        start_go = 1'b0;
        go_idle  = 1'b0;
      end
    endcase
  end

  always_comb begin
    load     = start_go | go_idle;
    load_val = '0;
    if (start_go && (mode != MODE_FILL)) load_val = SEED;
    else                                 load_val = '0;
  end

  // Ping-pong bounces on the same tick the dot reaches an end, so it never leaves.
  always_comb begin
    if ((lr == DIR_LEFT) && Q[WIDTH-1])  pong_dir = DIR_RIGHT;
    else if ((lr == DIR_RIGHT) && Q[0])  pong_dir = DIR_LEFT;
    else                                 pong_dir = lr;
  end

  // Per-pattern direction and serial-input selection.
  always_comb begin
    shift_dir = DIR_LEFT;
    rotate    = 1'b0;
    ser_in    = 1'b0;
    case (mode_reg)
      MODE_ROTL: begin
        shift_dir = DIR_LEFT;
        rotate    = 1'b1;
      end
      MODE_ROTR: begin
        shift_dir = DIR_RIGHT;
        rotate    = 1'b1;
      end
      MODE_PONG: begin
        shift_dir = pong_dir;
        rotate    = 1'b0;
      end
      MODE_FILL: begin
        shift_dir = DIR_LEFT;
        ser_in    = ~fill_flag;
      end
      default: begin
        shift_dir = DIR_LEFT;
        rotate    = 1'b0;
      end
    endcase
  end

  // Fill flag flips on the tick whose result is all ones or all zeros.
  always_comb begin
    fill_next = {Q[WIDTH-2:0], ser_in};
    fill_edge = (&fill_next) | ~(|fill_next);
  end

  // Divider, mode latch, fill flag, direction and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      mode_reg  <= MODE_ROTL;
      fill_flag <= 1'b0;
      lr        <= DIR_LEFT;
      busy      <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= shift_en;
      busy <= (next_state != IDLE);
      if (start_go) begin
        div_cnt <= '0;
      end else if (count_en) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      end
      if (start_go) begin
        mode_reg  <= mode;
        fill_flag <= 1'b0;
        lr        <= (mode == MODE_ROTR) ? DIR_RIGHT : DIR_LEFT;
      end else if (go_idle) begin
        lr <= DIR_LEFT;
      end else if (shift_en) begin
        lr <= shift_dir;
        if ((mode_reg == MODE_FILL) && fill_edge) fill_flag <= ~fill_flag;
      end
    end
  end

  shreg_lr #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .shift_en (shift_en),
    .lr       (shift_dir),
    .ser_in   (ser_in),
    .rotate   (rotate),
    .Q        (Q)
  );

endmodule
